// File: rtl/eq_pkg.sv
// Shared definitions for the EQ coefficient sequencer: sequencing states,
// coefficient select codes, coefficient width and default sizing.
package eq_pkg;

    localparam int COEF_W            = 32;
    localparam int NUM_SEL           = 4;
    localparam int DEF_NUM_BANDS     = 4;
    localparam int DEF_MUTE_FRAMES   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_MUTED  = 2'd2,
        ST_SETTLE = 2'd3
    } eq_state_t;

    typedef enum logic [1:0] {
        SEL_A1 = 2'd0,
        SEL_A2 = 2'd1,
        SEL_B1 = 2'd2,
        SEL_B2 = 2'd3
    } coef_sel_t;

    // Band index width: one code beyond the last band is always expressible,
    // so an out-of-range band arriving on the write port can be recognised.
    function automatic int band_w(input int num_bands);
        return $clog2(num_bands + 1);
    endfunction

endpackage

// File: rtl/eq_coef_sequencer_if.sv
// Control/coefficient bus of the EQ coefficient sequencer. The master side
// (host + frame timing) writes shadows and commits; the slave side is the
// sequencer, which presents active coefficients and audio gating.
interface eq_coef_sequencer_if #(
    parameter int NUM_BANDS = eq_pkg::DEF_NUM_BANDS
);
    import eq_pkg::*;

    localparam int BAND_W = band_w(NUM_BANDS);

    logic                          frame_start;
    logic                          wr_en;
    logic [BAND_W-1:0]             wr_band;
    logic [1:0]                    wr_sel;
    logic [COEF_W-1:0]             wr_data;
    logic                          commit;
    logic [NUM_BANDS*COEF_W-1:0]   a1_out;
    logic [NUM_BANDS*COEF_W-1:0]   a2_out;
    logic [NUM_BANDS*COEF_W-1:0]   b1_out;
    logic [NUM_BANDS*COEF_W-1:0]   b2_out;
    logic                          audio_on;
    logic                          busy;
    logic                          done;

    modport master (
        output frame_start, wr_en, wr_band, wr_sel, wr_data, commit,
        input  a1_out, a2_out, b1_out, b2_out, audio_on, busy, done
    );

    modport slave (
        input  frame_start, wr_en, wr_band, wr_sel, wr_data, commit,
        output a1_out, a2_out, b1_out, b2_out, audio_on, busy, done
    );

endinterface

// File: rtl/eq_coef_bank.sv
// Shadow and active coefficient storage. Writes land in shadow only; a load
// strobe copies every shadow into active in one edge. A write coinciding
// with the load is forwarded so it is part of that load.
module eq_coef_bank
    import eq_pkg::*;
#(
    parameter int NUM_BANDS = DEF_NUM_BANDS,
    parameter int BAND_W    = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        wr_en,
    input  logic [BAND_W-1:0]           wr_band,
    input  logic [1:0]                  wr_sel,
    input  logic [COEF_W-1:0]           wr_data,
    input  logic                        load,
    output logic [NUM_BANDS*COEF_W-1:0] a1_out,
    output logic [NUM_BANDS*COEF_W-1:0] a2_out,
    output logic [NUM_BANDS*COEF_W-1:0] b1_out,
    output logic [NUM_BANDS*COEF_W-1:0] b2_out
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANDS; gi++) begin : g_band
            logic              band_hit;
            logic [COEF_W-1:0] sh_a1_reg, sh_a2_reg, sh_b1_reg, sh_b2_reg;
            logic [COEF_W-1:0] sh_a1_next, sh_a2_next, sh_b1_next, sh_b2_next;
            logic [COEF_W-1:0] ac_a1_reg, ac_a2_reg, ac_b1_reg, ac_b2_reg;

            // Band indices at or above NUM_BANDS never match any band here.
            assign band_hit = wr_en && (wr_band == BAND_W'(gi));

            // Shadow contents after this edge's write (used for both store and load).
            always_comb begin
                sh_a1_next = sh_a1_reg;
                sh_a2_next = sh_a2_reg;
                sh_b1_next = sh_b1_reg;
                sh_b2_next = sh_b2_reg;
                if (band_hit) begin
                    case (coef_sel_t'(wr_sel))
                        SEL_A1: sh_a1_next = wr_data;
                        SEL_A2: sh_a2_next = wr_data;
                        SEL_B1: sh_b1_next = wr_data;
                        SEL_B2: sh_b2_next = wr_data;
                    endcase
                end
            end

            // Shadow always tracks writes; active changes only on the load strobe.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sh_a1_reg <= '0;
                    sh_a2_reg <= '0;
                    sh_b1_reg <= '0;
                    sh_b2_reg <= '0;
                    ac_a1_reg <= '0;
                    ac_a2_reg <= '0;
                    ac_b1_reg <= '0;
                    ac_b2_reg <= '0;
                end else begin
                    sh_a1_reg <= sh_a1_next;
                    sh_a2_reg <= sh_a2_next;
                    sh_b1_reg <= sh_b1_next;
                    sh_b2_reg <= sh_b2_next;
                    if (load) begin
                        ac_a1_reg <= sh_a1_next;
                        ac_a2_reg <= sh_a2_next;
                        ac_b1_reg <= sh_b1_next;
                        ac_b2_reg <= sh_b2_next;
                    end
                end
            end

            assign a1_out[gi*COEF_W +: COEF_W] = ac_a1_reg;
            assign a2_out[gi*COEF_W +: COEF_W] = ac_a2_reg;
            assign b1_out[gi*COEF_W +: COEF_W] = ac_b1_reg;
            assign b2_out[gi*COEF_W +: COEF_W] = ac_b2_reg;
        end
    endgenerate

endmodule

// File: rtl/eq_coef_sequencer.sv
// Glitch-free biquad coefficient update: on commit, mute audio at the next
// frame, hold mute for MUTE_FRAMES frames, swap all coefficients atomically,
// let the filters run one muted frame on the new set, then unmute.
module eq_coef_sequencer
    import eq_pkg::*;
#(
    parameter int NUM_BANDS   = DEF_NUM_BANDS,
    parameter int MUTE_FRAMES = DEF_MUTE_FRAMES
) (
    input  logic                 clk,
    input  logic                 reset_n,
    eq_coef_sequencer_if.slave   bus
);

    localparam int              BAND_W   = band_w(NUM_BANDS);
    localparam logic [7:0]      LAST_CNT = 8'(MUTE_FRAMES - 1);

    eq_state_t  state_reg, state_next;
    logic [7:0] frame_cnt_reg, frame_cnt_next;
    logic       pending_reg, pending_next;
    logic       audio_on_reg, audio_on_next;
    logic       done_reg, done_next;
    logic       busy_reg;
    logic       load;

    // Next-state, frame counting, pending-commit capture and output intent.
    always_comb begin
        state_next     = state_reg;
        frame_cnt_next = frame_cnt_reg;
        pending_next   = pending_reg | (bus.commit && (state_reg != ST_IDLE));
        audio_on_next  = audio_on_reg;
        done_next      = 1'b0;
        load           = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // A frame_start in this same cycle is deliberately not the arming frame.
                if (bus.commit || pending_reg) begin
                    state_next   = ST_ARM;
                    pending_next = 1'b0;
                end
            end
            ST_ARM: begin
                if (bus.frame_start) begin
                    audio_on_next  = 1'b0;
                    frame_cnt_next = '0;
                    state_next     = ST_MUTED;
                end
            end
            ST_MUTED: begin
                if (bus.frame_start) begin
                    frame_cnt_next = frame_cnt_reg + 8'd1;
                    if (frame_cnt_reg == LAST_CNT) begin
                        load       = 1'b1;
                        state_next = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (bus.frame_start) begin
                    audio_on_next = 1'b1;
                    done_next     = 1'b1;
                    state_next    = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any update in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            frame_cnt_reg <= '0;
            pending_reg   <= 1'b0;
            audio_on_reg  <= 1'b0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            frame_cnt_reg <= frame_cnt_next;
            pending_reg   <= pending_next;
            audio_on_reg  <= audio_on_next;
            done_reg      <= done_next;
            busy_reg      <= (state_next != ST_IDLE);
        end
    end

    eq_coef_bank #(
        .NUM_BANDS (NUM_BANDS),
        .BAND_W    (BAND_W)
    ) u_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (bus.wr_en),
        .wr_band (bus.wr_band),
        .wr_sel  (bus.wr_sel),
        .wr_data (bus.wr_data),
        .load    (load),
        .a1_out  (bus.a1_out),
        .a2_out  (bus.a2_out),
        .b1_out  (bus.b1_out),
        .b2_out  (bus.b2_out)
    );

    assign bus.audio_on = audio_on_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;

endmodule

// File: tb/tb_eq_coef_sequencer.sv
// Randomised and directed bench for eq_coef_sequencer. A frame-count
// reference model predicts coefficients/gating; completed updates are
// queued and checked by an independent monitor when done pulses.
module tb_eq_coef_sequencer;
    import eq_pkg::*;

    localparam int NB = 4;
    localparam int MF = 4;
    localparam int BW = band_w(NB);
    localparam int FW = NB * 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    eq_coef_sequencer_if #(.NUM_BANDS(NB)) bus();

    eq_coef_sequencer #(.NUM_BANDS(NB), .MUTE_FRAMES(MF)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [FW-1:0] a1, a2, b1, b2;
        int            id;
    } snap_t;

    snap_t exp_q[$];

    // Reference model state
    logic [31:0] m_sh  [NB][4];
    logic [31:0] m_act [NB][4];
    bit  m_busy, m_pending, m_audio, m_done;
    int  m_frames;
    int  m_updates;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] flat(input int sel);
        logic [FW-1:0] v;
        v = '0;
        for (int b = 0; b < NB; b++) v[b*32 +: 32] = m_act[b][sel];
        return v;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++)
            for (int s = 0; s < 4; s++) begin
                m_sh[b][s]  = '0;
                m_act[b][s] = '0;
            end
        m_busy = 0; m_pending = 0; m_audio = 0; m_done = 0; m_frames = 0;
        exp_q.delete();
    endtask

    // One clock edge of the specified behaviour, in frame-count terms:
    // frame 1 after acceptance mutes, frame MF+1 swaps, frame MF+2 unmutes.
    task automatic model_edge();
        int b;
        snap_t s;
        m_done = 0;
        if (!reset_n) return;
        b = int'(bus.wr_band);
        if (bus.wr_en && b < NB) m_sh[b][int'(bus.wr_sel)] = bus.wr_data;
        if (!m_busy) begin
            if (bus.commit || m_pending) begin
                m_busy = 1; m_frames = 0; m_pending = 0;
            end
        end else begin
            if (bus.commit) m_pending = 1;
            if (bus.frame_start) begin
                m_frames++;
                if (m_frames == 1) m_audio = 0;
                if (m_frames == MF + 1) m_act = m_sh;
                if (m_frames == MF + 2) begin
                    m_audio = 1; m_busy = 0; m_done = 1;
                    m_updates++;
                    s.a1 = flat(0); s.a2 = flat(1); s.b1 = flat(2); s.b2 = flat(3);
                    s.id = m_updates;
                    exp_q.push_back(s);
                end
            end
        end
    endtask

    // Monitor: per-cycle gating/coefficients vs model, scoreboard pop on done.
    always @(negedge clk) begin
        snap_t s;
        check("audio_on", FW'(bus.audio_on), FW'(m_audio));
        check("busy", FW'(bus.busy), FW'(m_busy));
        check("done", FW'(bus.done), FW'(m_done));
        check("a1_out", bus.a1_out, flat(0));
        check("a2_out", bus.a2_out, flat(1));
        check("b1_out", bus.b1_out, flat(2));
        check("b2_out", bus.b2_out, flat(3));
        if (bus.done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                s = exp_q.pop_front();
                check("upd_a1", bus.a1_out, s.a1);
                check("upd_a2", bus.a2_out, s.a2);
                check("upd_b1", bus.b1_out, s.b1);
                check("upd_b2", bus.b2_out, s.b2);
                $display("update %0d complete at %0t: a1=%h b2=%h", s.id, $time, s.a1, s.b2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        bus.frame_start = 1'b0;
        bus.commit      = 1'b0;
        bus.wr_en       = 1'b0;
    endtask

    task automatic drive(input bit fs, input bit cm, input bit we,
                         input int band, input int sel, input logic [31:0] data);
        bus.frame_start = fs;
        bus.commit      = cm;
        bus.wr_en       = we;
        bus.wr_band     = BW'(band);
        bus.wr_sel      = 2'(sel);
        bus.wr_data     = data;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic frame();
        drive(1, 0, 0, 0, 0, 0);
        idle(3);
    endtask

    task automatic write(input int band, input int sel, input logic [31:0] data);
        drive(0, 0, 1, band, sel, data);
    endtask

    task automatic do_reset(input string name);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check({name, "_audio"}, FW'(bus.audio_on), 0);
        check({name, "_busy"}, FW'(bus.busy), 0);
        check({name, "_done"}, FW'(bus.done), 0);
        check({name, "_a1"}, bus.a1_out, 0);
        check({name, "_b2"}, bus.b2_out, 0);
        idle(3);
        reset_n = 1'b1;
    endtask

    initial begin
        int rose, chg, aud_at, d0;
        logic [FW-1:0] save_a1, save_b2;

        bus.frame_start = 0; bus.commit = 0; bus.wr_en = 0;
        bus.wr_band = '0; bus.wr_sel = '0; bus.wr_data = '0;
        m_updates = 0;
        model_reset();
        idle(3);
        check("rst_audio", FW'(bus.audio_on), 0);
        check("rst_busy", FW'(bus.busy), 0);
        check("rst_a1", bus.a1_out, 0);
        reset_n = 1'b1;
        idle(2);

        // All-zero update: unmute on 6th frame after commit, one done.
        d0 = done_seen;
        drive(0, 1, 0, 0, 0, 0);
        rose = -1;
        for (int f = 1; f <= 8; f++) begin
            drive(1, 0, 0, 0, 0, 0);
            if (bus.audio_on && rose < 0) rose = f;
            idle(3);
        end
        check("zero_unmute_frame", FW'(rose), 6);
        check("zero_done_count", FW'(done_seen - d0), 1);

        // Band 2 a1 swaps exactly at 5th frame, while muted.
        write(2, 0, 32'h0F85_1EB8);
        drive(0, 1, 0, 0, 0, 0);
        chg = -1; aud_at = -1;
        for (int f = 1; f <= 8; f++) begin
            drive(1, 0, 0, 0, 0, 0);
            if (bus.a1_out[95:64] == 32'h0F85_1EB8 && chg < 0) begin
                chg = f; aud_at = int'(bus.audio_on);
            end
            idle(3);
        end
        check("a1_swap_frame", FW'(chg), 5);
        check("a1_swap_muted", FW'(aud_at), 0);

        // Write + commit + frame_start together: that frame does not mute.
        drive(1, 1, 1, 1, 3, 32'h0800_0000);
        check("same_cycle_no_mute", FW'(bus.audio_on), 1);
        drive(1, 0, 0, 0, 0, 0);
        check("next_frame_mutes", FW'(bus.audio_on), 0);
        idle(3);
        repeat (7) frame();
        check("b2_band1_loaded", FW'(bus.b2_out[63:32]), FW'(32'h0800_0000));

        // Commit during MUTED and during SETTLE coalesce into one re-run.
        d0 = done_seen;
        drive(0, 1, 0, 0, 0, 0);
        frame(); frame();
        drive(0, 1, 0, 0, 0, 0);
        frame(); frame(); frame();
        drive(0, 1, 0, 0, 0, 0);
        repeat (16) frame();
        check("pending_done_count", FW'(done_seen - d0), 2);

        // Reset while muted: everything clears and stays idle.
        write(0, 0, 32'h1111_1111);
        write(3, 2, 32'h2222_2222);
        drive(0, 1, 0, 0, 0, 0);
        frame(); frame(); frame();
        do_reset("mid_reset");
        d0 = done_seen;
        repeat (10) frame();
        check("post_reset_busy", FW'(bus.busy), 0);
        check("post_reset_audio", FW'(bus.audio_on), 0);
        check("post_reset_no_done", FW'(done_seen - d0), 0);

        // Out-of-range band writes are dropped.
        write(0, 1, 32'h0000_1234);
        write(1, 3, 32'h0000_5678);
        drive(0, 1, 0, 0, 0, 0);
        repeat (8) frame();
        save_a1 = flat(0);
        save_b2 = flat(3);
        write(7, 0, 32'hDEAD_BEEF);
        write(7, 3, 32'hCAFE_F00D);
        write(4, 3, 32'hCAFE_F00D);
        d0 = done_seen;
        drive(0, 1, 0, 0, 0, 0);
        repeat (8) frame();
        check("oob_done", FW'(done_seen - d0), 1);
        check("oob_a1_kept", bus.a1_out, save_a1);
        check("oob_b2_kept", bus.b2_out, save_b2);

        // Random traffic against the model, with one reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset("rand_reset");
            drive(($urandom_range(0, 4) == 0), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 3)), $urandom);
        end
        repeat (20) frame();
        check("queue_drained", FW'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
